// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among N_REQ requesters.
// Bursts end on packet last, a beat cap, or an owner-idle timeout.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 8,
  parameter int STALL_MAX = 4,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   fifo_wr_en,
  output logic [WIDTH-1:0]       fifo_din,
  input  logic                   fifo_full,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic [7:0]       r_burst_cnt;
  logic [7:0]       r_stall_cnt;

  logic [N_REQ-1:0] w_rot;
  logic             w_any;
  logic [IDW:0]     w_off;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_winner;
  logic [IDW:0]     w_inc;
  logic [IDW-1:0]   w_rr_nxt;

  logic             w_own_valid;
  logic             w_own_last;
  logic [WIDTH-1:0] w_own_data;
  logic             w_busy;
  logic             w_xfer;
  logic             w_stall_inc;
  logic [8:0]       w_burst_inc;
  logic [8:0]       w_stall_nxt;
  logic             w_cap;
  logic             w_stall_hit;
  logic             w_end;

  // Rotate requests so bit 0 is rr_ptr; lowest set bit is the winner.
  assign w_rot = N_REQ'({req_valid, req_valid} >> r_rr_ptr);

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = (IDW+1)'(k);
      end
    end
  end

  assign w_sum    = {1'b0, r_rr_ptr} + w_off;
  assign w_winner = (w_sum >= (IDW+1)'(N_REQ))
                  ? IDW'(w_sum - (IDW+1)'(N_REQ))
                  : IDW'(w_sum);

  assign w_inc    = {1'b0, r_grant_id} + (IDW+1)'(1);
  assign w_rr_nxt = (w_inc == (IDW+1)'(N_REQ)) ? '0 : IDW'(w_inc);

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_id == IDW'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_busy      = (r_state == GRANT);
  assign w_xfer      = w_busy & w_own_valid & ~fifo_full;
  // Backpressure is not idleness: stall only counts with room in the FIFO.
  assign w_stall_inc = w_busy & ~w_own_valid & ~fifo_full;

  assign w_burst_inc = {1'b0, r_burst_cnt} + 9'd1;
  assign w_stall_nxt = {1'b0, r_stall_cnt} + 9'd1;
  assign w_cap       = (w_burst_inc == 9'(MAX_BURST));
  assign w_stall_hit = (w_stall_nxt == 9'(STALL_MAX));

  assign w_end = (w_xfer & (w_own_last | w_cap))
               | (w_stall_inc & w_stall_hit);

  always_comb begin
    req_ready = '0;
    if (w_busy && !fifo_full) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (r_grant_id == IDW'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  assign fifo_wr_en = w_xfer;
  assign fifo_din   = w_own_data;
  assign grant_id   = r_grant_id;
  assign busy       = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_nxt = GRANT;
      GRANT:   if (w_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_grant_id  <= w_winner;
        r_burst_cnt <= '0;
        r_stall_cnt <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
        r_stall_cnt <= '0;
      end else if (w_stall_inc) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
      if (w_end) r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packets per requester,
// expected write stream queued up front and checked by a write monitor.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic           fifo_full;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_wr_arbiter #(
    .N_REQ(N), .WIDTH(W), .MAX_BURST(8), .STALL_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] bq[N][$];
  bit          lq[N][$];
  bit          gate[N];
  bit          full_req;
  logic [N-1:0] acc;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [15:0] mk(int r, int b);
    return {4'(r), 12'(b)};
  endfunction

  function void apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = gate[i] && (bq[i].size() > 0);
      req_data[i*W +: W] = (bq[i].size() > 0) ? bq[i][0] : 16'h0;
      req_last[i] = (bq[i].size() > 0) ? lq[i][0] : 1'b0;
    end
    fifo_full = full_req;
  endfunction

  task automatic push(int r, int n, int first, bit lst);
    for (int b = first; b < first + n; b++) begin
      bq[r].push_back(mk(r, b));
      lq[r].push_back(lst && (b == first + n - 1));
    end
  endtask

  task automatic expect_b(int r, int first, int n);
    for (int b = first; b < first + n; b++)
      exp_q.push_back({2'(r), mk(r, b)});
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Accept happens at the edge where valid & ready held during the cycle.
  always @(negedge clk) acc = req_valid & req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && bq[i].size() > 0) begin
        void'(bq[i].pop_front());
        void'(lq[i].pop_front());
      end
    end
    acc = '0;
    apply();
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got id%0d din %0h want none",
                 grant_id, fifo_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({grant_id, fifo_din} !== mon_e) begin
          n_err++;
          $display("FAIL write: got id%0d din %0h want id%0d din %0h",
                   grant_id, fifo_din, mon_e[17:16], mon_e[15:0]);
        end
      end
    end
  end

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      lq[i].delete();
      gate[i] = 1'b1;
    end
    full_req = 1'b0;
    acc = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(int budget);
    int c = 0;
    while ((exp_q.size() > 0 || busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    apply();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    do_reset();

    // single 3-beat packet from requester 0
    @(posedge clk);
    push(0, 3, 1, 1);
    expect_b(0, 1, 3);
    @(negedge clk);
    chk("t1_c0_busy", busy, 0);
    @(negedge clk);
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_wr", fifo_wr_en, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_c3_wr", fifo_wr_en, 1);
    @(negedge clk);
    chk("t1_c4_busy", busy, 0);
    chk("t1_c4_wr", fifo_wr_en, 0);
    // rr_ptr now 1: requester 1 beats requester 0
    @(posedge clk);
    push(0, 1, 10, 1);
    push(1, 1, 10, 1);
    expect_b(1, 10, 1);
    expect_b(0, 10, 1);
    wait_drain(50);

    // round robin of 1-beat packets
    do_reset();
    @(posedge clk);
    push(0, 1, 1, 1);
    push(0, 1, 2, 1);
    push(1, 1, 1, 1);
    push(2, 1, 1, 1);
    push(3, 1, 1, 1);
    expect_b(0, 1, 1);
    expect_b(1, 1, 1);
    expect_b(2, 1, 1);
    expect_b(3, 1, 1);
    expect_b(0, 2, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t2_wr_c%0d", k), fifo_wr_en, (k % 2 == 1));
    end
    wait_drain(50);

    // backpressure mid-burst on owner 2
    do_reset();
    @(posedge clk);
    push(2, 6, 1, 1);
    expect_b(2, 1, 6);
    repeat (3) @(negedge clk);
    @(posedge clk);
    full_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t3_ready_c%0d", k), req_ready[2], 0);
      chk($sformatf("t3_wr_c%0d", k), fifo_wr_en, 0);
      chk($sformatf("t3_busy_c%0d", k), busy, 1);
    end
    @(posedge clk);
    full_req = 1'b0;
    wait_drain(60);

    // burst cap splits requester 1, requester 3 interleaves
    do_reset();
    @(posedge clk);
    push(1, 20, 1, 0);
    push(3, 3, 1, 1);
    expect_b(1, 1, 8);
    expect_b(3, 1, 3);
    expect_b(1, 9, 8);
    expect_b(1, 17, 4);
    wait_drain(200);

    // stall timeout after owner 0 goes idle
    do_reset();
    @(posedge clk);
    push(0, 2, 1, 0);
    push(1, 1, 1, 1);
    expect_b(0, 1, 2);
    expect_b(1, 1, 1);
    repeat (7) @(negedge clk);
    chk("t5_c6_busy", busy, 1);
    @(negedge clk);
    chk("t5_c7_busy", busy, 0);
    @(negedge clk);
    chk("t5_c8_wr", fifo_wr_en, 1);
    chk("t5_c8_grant", grant_id, 1);
    wait_drain(50);

    // owner 0 idles 3 cycles, returns, keeps grant
    do_reset();
    @(posedge clk);
    push(0, 2, 1, 0);
    push(1, 1, 1, 1);
    expect_b(0, 1, 2);
    expect_b(1, 1, 1);
    repeat (2) @(posedge clk);
    gate[0] = 1'b0;
    repeat (3) @(posedge clk);
    gate[0] = 1'b1;
    wait_drain(60);

    // reset during beat 2 of 5
    do_reset();
    @(posedge clk);
    push(0, 5, 1, 1);
    expect_b(0, 1, 2);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_wr", fifo_wr_en, 0);
    chk("t7_rst_ready", req_ready, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_beats_seen", exp_q.size(), 0);
    clear_reqs();
    exp_q.delete();
    push(0, 1, 7, 1);
    push(1, 1, 7, 1);
    expect_b(0, 7, 1);
    expect_b(1, 7, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's async FIFO among N_REQ requesters in the FIFO's write-clock domain.
- Round-robin arbiter: grants one requester at a time for a burst. A burst ends on a packet-last beat, a beat cap, or an owner-stall timeout.
- Drives the FIFO's wr_en/din and obeys its registered full flag, so no beat is ever presented to a full FIFO.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, data width; equals the FIFO WIDTH.
- MAX_BURST, 8, maximum beats per grant (1..255).
- STALL_MAX, 4, consecutive owner-idle cycles that force a grant release (1..255).

Ports:
- clk  in  1  write-side clock (same clock as the FIFO wr_clk).
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  N_REQ  marks the final beat of a packet; qualified by valid.
- req_ready  out  N_REQ  per-requester beat accept.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_din  out  WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  max(1,$clog2(N_REQ))  current or last owner.
- busy  out  1  high while in GRANT.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE, rr_ptr = 0, grant_id = 0, busy = 0.
  - burst_cnt = 0, stall_cnt = 0.
  - req_ready = 0, fifo_wr_en = 0.
  - fifo_din has no reset requirement, but must be driven by the owner mux, never X-gated into wr_en.
- FSM states: IDLE, GRANT.
- IDLE:
  - busy = 0; all req_ready = 0.
  - If any req_valid is set, pick the first set bit scanning from rr_ptr upward, wrapping modulo N_REQ.
  - On that edge: grant_id <= winner, burst_cnt <= 0, stall_cnt <= 0, state <= GRANT.
  - Arbitration latency is 1 cycle: no beat transfers in IDLE.
- GRANT, combinational outputs:
  - busy = 1.
  - req_ready[grant_id] = !fifo_full; all other req_ready = 0.
  - fifo_wr_en = req_valid[grant_id] && !fifo_full.
  - fifo_din = req_data[grant_id].
- A beat transfers in any cycle where fifo_wr_en = 1. The FIFO's full is a look-ahead flag, so a combinational wr_en is overflow-safe.
- burst_cnt increments on each transfer.
- stall_cnt:
  - increments when req_valid[grant_id] = 0 and fifo_full = 0;
  - clears on a transfer;
  - holds while fifo_full = 1, because backpressure is never counted as a stall.
- Burst end: at the edge where any of the following holds, state <= IDLE and rr_ptr <= (grant_id+1) mod N_REQ:
  - (a) a transfer carries req_last[grant_id] = 1;
  - (b) a transfer makes burst_cnt reach MAX_BURST;
  - (c) stall_cnt reaches STALL_MAX.
- (a) and (b) together count as a single end. grant_id holds its value in IDLE.
- The only way out of GRANT is a burst end; the FSM has no other exit.
- Boundary conditions:
  - FIFO full for the whole grant: the grant is held indefinitely. No beats transfer and no timeout fires.
  - A requester that drops valid and re-raises it before STALL_MAX keeps the grant.
  - Non-owner requests are ignored during GRANT. They are served in round-robin order afterwards.
  - A single active requester is re-granted after a one-cycle IDLE bubble.
  - rr_ptr wraps from N_REQ-1 to 0.
  - Reset mid-burst abandons the burst immediately. No further writes occur; the partial packet already in the FIFO stays there (downstream must tolerate truncation).
- Packets longer than MAX_BURST are split across grants. Other requesters may interleave between the pieces.

Test Plan:
- Single packet: req_valid[0] = 1 with a 3-beat packet (last on beat 3), fifo_full = 0.
  - Expect busy rising at cycle 1.
  - Expect fifo_wr_en high on cycles 1–3 with din = beats 1–3.
  - Expect IDLE at cycle 4 and rr_ptr = 1.
- Round robin: requesters 0–3 all valid with 1-beat packets.
  - Expect grant order 0, 1, 2, 3, 0, each grant lasting 2 cycles (1 IDLE + 1 GRANT).
- Backpressure: owner 2 valid, fifo_full forced high for 10 cycles mid-burst.
  - Expect req_ready[2] = 0 and fifo_wr_en = 0 throughout those cycles, no release, and stall_cnt unchanged.
  - On full deasserting, transfers resume with no beat lost or duplicated.
- Burst cap: requester 1 sends 20 beats with no last, MAX_BURST = 8, requester 3 also valid.
  - Expect beats 1–8 from requester 1, then requester 3's packet, then beats 9–16 from requester 1.
- Stall timeout: owner 0 sends 2 beats, then valid = 0 with STALL_MAX = 4.
  - Expect release after the 4th idle cycle, then requester 1 granted if it is valid.
- Reset mid-burst: assert rst_n low during beat 2 of 5.
  - Expect fifo_wr_en = 0, all req_ready = 0 and busy = 0 immediately (asynchronous).
  - After release, expect requester 0 to win first.
